// File: rtl/tdm_demux_8ch.sv
// tdm_demux_8ch: slot-counting serial-to-parallel TDM demultiplexer with frame sync lock
module tdm_demux_8ch #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [N-1:0]     d_out,
  output logic             frame_valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err
);
  logic [N-1:0] shadow;
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out       <= '0;
      frame_valid <= 1'b0;
      slot        <= '0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      shadow      <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        if (frame_sync) begin
          shadow   <= {{(N-1){1'b0}}, din};
          slot     <= SEL_W'(1);
          locked   <= 1'b1;
          sync_err <= locked && (slot != '0);
        end else if (locked) begin
          shadow[slot] <= din;
          if (slot == SEL_W'(N-1)) begin
            d_out       <= {din, shadow[N-2:0]};
            frame_valid <= 1'b1;
            slot        <= '0;
          end else begin
            slot <= slot + SEL_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_8ch.sv
// tb_tdm_demux_8ch: table-driven and directed checks of the TDM demultiplexer
module tb_tdm_demux_8ch;
  logic clk = 1'b0, rst = 1'b0, din = 1'b0, din_valid = 1'b0, frame_sync = 1'b0;
  logic [7:0] d_out;
  logic frame_valid, locked, sync_err;
  logic [2:0] slot;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic r, dv, fs, b;
    logic [7:0] d;
    logic fv;
    logic [2:0] sl;
    logic lk, er;
  } vec_t;
  vec_t vecs[$];
  tdm_demux_8ch #(.N(8), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .d_out(d_out), .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, dv, fs, b, logic [7:0] d, logic fv, logic [2:0] sl, logic lk, er);
    return '{r, dv, fs, b, d, fv, sl, lk, er};
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, got, want);
    end
  endtask
  task automatic drive(input logic r, input logic dv, input logic fs, input logic b);
    @(negedge clk);
    rst = r; din_valid = dv; frame_sync = fs; din = b;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_all(input string t, input logic [7:0] d, input logic fv, input logic [2:0] sl, input logic lk, input logic er);
    chk({t, " d_out"}, 32'(d_out), 32'(d));
    chk({t, " frame_valid"}, 32'(frame_valid), 32'(fv));
    chk({t, " slot"}, 32'(slot), 32'(sl));
    chk({t, " locked"}, 32'(locked), 32'(lk));
    chk({t, " sync_err"}, 32'(sync_err), 32'(er));
  endtask
  initial begin
    logic [7:0] p;
    vecs.push_back(v(1,0,0,0, 8'h00,0,0,0,0));
    vecs.push_back(v(0,1,1,1, 8'h00,0,1,1,0));
    vecs.push_back(v(0,1,0,0, 8'h00,0,2,1,0));
    vecs.push_back(v(0,1,0,1, 8'h00,0,3,1,0));
    vecs.push_back(v(0,1,0,0, 8'h00,0,4,1,0));
    vecs.push_back(v(0,1,0,0, 8'h00,0,5,1,0));
    vecs.push_back(v(0,1,0,1, 8'h00,0,6,1,0));
    vecs.push_back(v(0,1,0,0, 8'h00,0,7,1,0));
    vecs.push_back(v(0,1,0,1, 8'hA5,1,0,1,0));
    vecs.push_back(v(0,0,0,0, 8'hA5,0,0,1,0));
    vecs.push_back(v(1,0,0,0, 8'h00,0,0,0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(v(0,1,0,1, 8'h00,0,0,0,0));
    vecs.push_back(v(0,1,1,0, 8'h00,0,1,1,0));
    vecs.push_back(v(0,1,0,0, 8'h00,0,2,1,0));
    vecs.push_back(v(0,1,0,1, 8'h00,0,3,1,0));
    vecs.push_back(v(0,1,0,1, 8'h00,0,4,1,0));
    vecs.push_back(v(0,1,0,1, 8'h00,0,5,1,0));
    vecs.push_back(v(0,1,0,1, 8'h00,0,6,1,0));
    vecs.push_back(v(0,1,0,0, 8'h00,0,7,1,0));
    vecs.push_back(v(0,1,0,0, 8'h3C,1,0,1,0));
    vecs.push_back(v(0,1,1,1, 8'h3C,0,1,1,0));
    for (int i = 2; i < 8; i++) vecs.push_back(v(0,1,0,0, 8'h3C,0,3'(i),1,0));
    vecs.push_back(v(0,1,0,0, 8'h01,1,0,1,0));
    for (int i = 1; i < 8; i++) vecs.push_back(v(0,1,0,0, 8'h01,0,3'(i),1,0));
    vecs.push_back(v(0,1,0,1, 8'h80,1,0,1,0));
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].dv, vecs[i].fs, vecs[i].b);
      expect_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].fv, vecs[i].sl, vecs[i].lk, vecs[i].er);
    end
    for (int i = 0; i < 8; i++) begin
      int k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        drive(0, 0, 0, 0);
        expect_all($sformatf("gap%0d_%0d", i, j), 8'h80, 0, 3'(i), 1, 0);
      end
      drive(0, 1, i == 0, 1);
      expect_all($sformatf("ff%0d", i), i == 7 ? 8'hFF : 8'h80, i == 7, 3'(i + 1), 1, 0);
    end
    drive(0, 1, 1, 1);
    for (int i = 1; i < 5; i++) drive(0, 1, 0, 0);
    chk("pre_resync slot", 32'(slot), 32'd5);
    drive(0, 1, 1, 0);
    expect_all("resync", 8'hFF, 0, 1, 1, 1);
    p = 8'h5A;
    for (int i = 1; i < 8; i++) begin
      drive(0, 1, 0, p[i]);
      expect_all($sformatf("5a%0d", i), i == 7 ? 8'h5A : 8'hFF, i == 7, 3'(i + 1), 1, 0);
    end
    drive(0, 0, 0, 0);
    expect_all("post5a", 8'h5A, 0, 0, 1, 0);
    drive(0, 1, 1, 1);
    for (int i = 1; i < 7; i++) drive(0, 1, 0, 1);
    chk("pre_collide slot", 32'(slot), 32'd7);
    drive(0, 1, 1, 1);
    expect_all("collide", 8'h5A, 0, 1, 1, 1);
    for (int i = 1; i < 4; i++) drive(0, 1, 0, 1);
    chk("pre_rst slot", 32'(slot), 32'd4);
    drive(1, 1, 1, 1);
    expect_all("midrst", 8'h00, 0, 0, 0, 0);
    for (int i = 4; i < 8; i++) begin
      drive(0, 1, 0, 1);
      expect_all($sformatf("postrst%0d", i), 8'h00, 0, 0, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux_8ch.md
Name: tdm_demux_8ch

Overview:
- Receiving end of the 8:1 select path: converts a serial time-division stream, one bit per slot, back into an N-bit parallel word.
- The bit received in slot k lands on d_out[k]. This mirrors the mux convention where sel=k drives d[k] onto y.
- Sits downstream of the mux-based serializer. A slot counter replaces the external select lines; frame_sync marks slot 0.

Parameters:
- N, 8, number of channels/slots per frame (N >= 2)
- SEL_W, 3, slot counter width, ceil(log2(N))

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit for the current slot
- din_valid  input  1  din (and frame_sync) sampled this cycle
- frame_sync  input  1  qualified by din_valid; the current beat is slot 0
- d_out  output  N  last complete frame, registered; d_out[k] = slot-k bit
- frame_valid  output  1  one-cycle pulse when d_out is updated
- slot  output  SEL_W  slot index expected for the next valid beat
- locked  output  1  1 once the first frame_sync has been seen
- sync_err  output  1  one-cycle pulse on frame_sync at a nonzero expected slot

Behaviour:
- Reset (rst=1 at posedge): d_out=0, frame_valid=0, slot=0, locked=0, sync_err=0, shadow register=0. Reset has priority over all inputs, mid-frame included; any partial frame is discarded.
- All outputs are registered. frame_valid and sync_err are cleared by default every cycle and are never high for more than one cycle per event.
- din_valid=0: no state change except clearing the pulses. Gaps of any length between beats are legal.
- Unlocked, din_valid=1, frame_sync=0: the beat is ignored; slot stays 0.
- din_valid=1, frame_sync=1 (locked or not):
  - shadow is cleared, then shadow[0]=din; slot<=1; locked<=1.
  - If locked=1 and slot!=0: sync_err<=1; the partial frame is dropped with no frame_valid.
  - frame_sync at slot 0 is normal and raises no error.
- Locked, din_valid=1, frame_sync=0:
  - shadow[slot]<=din.
  - If slot==N-1: d_out <= shadow with bit N-1 = din; frame_valid<=1; slot<=0.
  - Otherwise slot<=slot+1.
- frame_sync is optional after lock. Slot wraps N-1 -> 0 and frames run back-to-back without it.
- Latency: d_out and frame_valid update at the clock edge after the slot N-1 beat is sampled, so they are visible in the following cycle. d_out holds its value until the next complete frame.
- Slot counter never exceeds N-1. With N not a power of two, the wrap is explicit at N-1, not a natural SEL_W overflow.
- Simultaneous frame_sync and slot==N-1: frame_sync wins. The frame is aborted, sync_err pulses, the bit goes to slot 0, and there is no frame_valid.
- locked clears only on rst.

Test Plan:
- Reset, then frame_sync with din=1 on beat 0, then beats 1..7 carrying bits of 8'hA5 LSB-first -> d_out=8'hA5, frame_valid high exactly one cycle after beat 7, slot=0, sync_err never asserted.
- Before any frame_sync, 5 valid beats of din=1 -> locked=0, slot=0, d_out=0, no frame_valid; a following synced frame 8'h3C -> d_out=8'h3C.
- Synced frame 8'h01, then an immediate second frame 8'h80 without frame_sync -> two frame_valid pulses 8 beats apart, d_out=8'h01 then 8'h80.
- Frame 8'hFF with random din_valid gaps of 0-3 idle cycles between beats -> d_out=8'hFF; no pulse or state change during idle cycles.
- frame_sync reasserted when slot=5 -> sync_err one-cycle pulse, no frame_valid, slot=1. The next 7 beats complete frame 8'h5A -> d_out=8'h5A.
- rst asserted after beat 4 of a frame -> all outputs 0 next cycle, locked=0. The remaining beats without frame_sync are ignored.
